bf16_add_issue: RTL and testbench
=================================

BF16_ADD_ISSUE -- requirements
Module: bf16_add_issue

Interface
REQ-001 Parameters: none; widths E=8 and M=7 come from bf16_pkg.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid_i  input  1  upstream operand pair valid.
REQ-005 in_ready_o  output  1  block can accept a pair this cycle.
REQ-006 a_i, b_i  input  16 each  packed bf16 operands {s, e[7:0], m[6:0]}.
REQ-007 out_valid_o  output  1  issued pair valid towards the adder.
REQ-008 out_ready_i  input  1  adder or downstream stage accepts the pair.
REQ-009 sa_o, sb_o  output  1 each  operand signs.
REQ-010 ea_o, eb_o  output  8 each  operand exponents.
REQ-011 ma_o, mb_o  output  7 each  operand mantissas.
REQ-012 byp_o  output  1  special case; the adder result is to be replaced by byp_res_o.
REQ-013 byp_res_o  output  16  precomputed special-case result; 0 when byp_o=0.

Function
REQ-014 Accept on in_valid_i&in_ready_o; issue on out_valid_o&out_ready_i; pairs issue in acceptance order, none dropped or duplicated.
REQ-015 Storage is a 2-entry skid buffer, main plus skid, with states EMPTY, ONE and FULL.
- EMPTY: accept goes to ONE.
- ONE: accept without issue goes to FULL; issue without accept goes to EMPTY; both together stay in ONE.
- FULL: issue goes to ONE, and skid moves into main.
REQ-016 in_ready_o is 1 in EMPTY and ONE, 0 in FULL, and is driven from a register.
REQ-017 out_valid_o is 1 in ONE and FULL; all output fields are driven from the main register.
REQ-018 Latency is 1 cycle from acceptance in EMPTY to out_valid_o=1.
REQ-019 Outputs stay stable while out_valid_o=1 and out_ready_i=0.
REQ-020 Classification and bypass are computed before registering. Per operand:
- e=0: ZERO; subnormals flush to zero and the field m is forced to 0.
- e=0xFF with m≠0: NAN.
- e=0xFF with m=0: INF.
- otherwise: NORM.
REQ-021 Bypass priority, first match wins:
- either operand NAN: 0x7FC0.
- INF and INF with opposite signs: 0x7FC0.
- any INF: that INF, {s, 0xFF, 0}.
- both ZERO: 0x8000 if both signs are 1, else 0x0000.
- one ZERO: the other operand unchanged.
- no match: byp_o=0.
REQ-022 For NORM/NORM pairs, issued fields equal the input fields bit-exactly.
REQ-023 Simultaneous accept and issue in ONE SHALL give zero bubbles (full throughput).

Reset
REQ-024 When rst=1 at a clock edge:
- state goes to EMPTY and out_valid_o=0.
- in_ready_o=1 from the next cycle.
- all data outputs are 0.
- any in-flight pairs are discarded.
REQ-025 rst takes priority over simultaneous accept or issue in the same cycle.

Configuration
REQ-026 Macro BF16_ADD_ISSUE_CNT_EN, when defined, adds two outputs:
- issue_cnt_o[15:0]: increments on every issue handshake.
- byp_cnt_o[15:0]: increments on issue handshakes with byp_o=1.
- both saturate at 0xFFFF and reset to 0.
REQ-027 Without the macro, neither port nor counter logic exists; all other behaviour is identical.

Structure
REQ-028 bf16_pkg holds:
- E, M.
- CANON_NAN=16'h7FC0.
- class enum {ZERO, NORM, INF, NAN}.
- the skid state enum.
REQ-029 One combinational sub-module, bf16_classify, returns class and flushed fields for one operand and is instantiated twice; the bypass table, skid buffer and counters stay in bf16_add_issue.

Verification
REQ-030 Pair 0x3F80/0x4000 accepted in EMPTY with out_ready_i=1 -> next cycle out_valid_o=1, ea_o=0x7F, eb_o=0x80, byp_o=0.
REQ-031 out_ready_i=0 with 3 back-to-back pairs:
- in_ready_o drops after 2 accepts.
- outputs hold pair 1.
- after releasing out_ready_i: pairs 1, 2, 3 issue in order on consecutive cycles.
REQ-032 Bypass table:
- 0x7F80 + 0xFF80 -> byp_res_o=0x7FC0.
- 0x7FC1 + 0x3F80 -> 0x7FC0.
- 0x8000 + 0x8000 -> 0x8000.
- 0x0001 + 0x4040 -> 0x4040 with byp_o=1.
REQ-033 rst asserted in FULL -> next cycle out_valid_o=0, in_ready_o=1, and no stale pair appears afterwards.
REQ-034 Continuous valid and ready for 100 pairs -> 100 issues in 101 cycles with no bubble.
REQ-035 With BF16_ADD_ISSUE_CNT_EN, 70000 issues including 5 bypasses -> issue_cnt_o=0xFFFF, byp_cnt_o=5.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared widths, classes and types for the bf16 adder issue stage.
package bf16_pkg;

  localparam int E = 8;
  localparam int M = 7;
  localparam logic [15:0] CANON_NAN = 16'h7FC0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_e;

  // One buffered entry: flushed operand fields plus the precomputed bypass.
  typedef struct packed {
    logic         sa;
    logic         sb;
    logic [E-1:0] ea;
    logic [E-1:0] eb;
    logic [M-1:0] ma;
    logic [M-1:0] mb;
    logic         byp;
    logic [15:0]  byp_res;
  } issue_t;

endpackage

// File: rtl/bf16_add_issue_if.sv
// Handshake bundle between the upstream source, the issue stage and the adder.
interface bf16_add_issue_if;
  import bf16_pkg::*;

  logic         in_valid_i;
  logic         in_ready_o;
  logic [15:0]  a_i;
  logic [15:0]  b_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         sa_o;
  logic         sb_o;
  logic [E-1:0] ea_o;
  logic [E-1:0] eb_o;
  logic [M-1:0] ma_o;
  logic [M-1:0] mb_o;
  logic         byp_o;
  logic [15:0]  byp_res_o;

  modport master (
    output in_valid_i, a_i, b_i, out_ready_i,
    input  in_ready_o, out_valid_o, sa_o, sb_o, ea_o, eb_o, ma_o, mb_o,
           byp_o, byp_res_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, out_ready_i,
    output in_ready_o, out_valid_o, sa_o, sb_o, ea_o, eb_o, ma_o, mb_o,
           byp_o, byp_res_o
  );

endinterface

// File: rtl/bf16_classify.sv
// Splits one bf16 operand into fields and a class; subnormals flush to ZERO.
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [15:0]  op_i,
  output fp_class_e    cls_o,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o
);

  always_comb begin
    s_o   = op_i[E+M];
    e_o   = op_i[E+M-1:M];
    m_o   = op_i[M-1:0];
    cls_o = NORM;
    if (e_o == '0) begin
      cls_o = ZERO;
      m_o   = '0;
    end else if (e_o == '1) begin
      cls_o = (m_o != '0) ? NAN : INF;
    end
  end

endmodule

// File: rtl/bf16_add_issue.sv
// bf16 adder issue stage: classify, precompute bypass, 2-entry skid buffer.
// Optional saturating issue/bypass counters under BF16_ADD_ISSUE_CNT_EN.
module bf16_add_issue
  import bf16_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
`ifdef BF16_ADD_ISSUE_CNT_EN
  output logic [15:0]        issue_cnt_o,
  output logic [15:0]        byp_cnt_o,
`endif
  bf16_add_issue_if.slave    bus
);

  fp_class_e    cls_a, cls_b;
  logic         s_a, s_b;
  logic [E-1:0] e_a, e_b;
  logic [M-1:0] m_a, m_b;

  bf16_classify u_cls_a (.op_i(bus.a_i), .cls_o(cls_a), .s_o(s_a), .e_o(e_a), .m_o(m_a));
  bf16_classify u_cls_b (.op_i(bus.b_i), .cls_o(cls_b), .s_o(s_b), .e_o(e_b), .m_o(m_b));

  issue_t      new_pair;
  skid_state_e state_q, state_d;
  issue_t      main_q, main_d, skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        accept, issue;

  assign accept = bus.in_valid_i & in_ready_q;
  assign issue  = out_valid_q & bus.out_ready_i;

  // Special-case table, first match wins.
  always_comb begin
    new_pair         = '{sa: s_a, sb: s_b, ea: e_a, eb: e_b, ma: m_a, mb: m_b,
                         byp: 1'b1, byp_res: 16'h0000};
    if (cls_a == NAN || cls_b == NAN)
      new_pair.byp_res = CANON_NAN;
    else if (cls_a == INF && cls_b == INF && s_a != s_b)
      new_pair.byp_res = CANON_NAN;
    else if (cls_a == INF)
      new_pair.byp_res = {s_a, {E{1'b1}}, {M{1'b0}}};
    else if (cls_b == INF)
      new_pair.byp_res = {s_b, {E{1'b1}}, {M{1'b0}}};
    else if (cls_a == ZERO && cls_b == ZERO)
      new_pair.byp_res = (s_a & s_b) ? 16'h8000 : 16'h0000;
    else if (cls_a == ZERO)
      new_pair.byp_res = bus.b_i;
    else if (cls_b == ZERO)
      new_pair.byp_res = bus.a_i;
    else
      new_pair.byp     = 1'b0;
  end

  // Skid buffer: main always feeds the outputs, skid only fills while stalled.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (accept) begin
        main_d  = new_pair;
        state_d = ONE;
      end
      ONE: begin
        if (accept && !issue) begin
          skid_d  = new_pair;
          state_d = FULL;
        end else if (accept && issue) begin
          main_d  = new_pair;
        end else if (issue) begin
          state_d = EMPTY;
        end
      end
      FULL: if (issue) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.sa_o        = main_q.sa;
  assign bus.sb_o        = main_q.sb;
  assign bus.ea_o        = main_q.ea;
  assign bus.eb_o        = main_q.eb;
  assign bus.ma_o        = main_q.ma;
  assign bus.mb_o        = main_q.mb;
  assign bus.byp_o       = main_q.byp;
  assign bus.byp_res_o   = main_q.byp_res;

`ifdef BF16_ADD_ISSUE_CNT_EN
  logic [15:0] issue_cnt_q, issue_cnt_d, byp_cnt_q, byp_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    byp_cnt_d   = byp_cnt_q;
    if (issue && issue_cnt_q != 16'hFFFF)
      issue_cnt_d = issue_cnt_q + 16'd1;
    if (issue && main_q.byp && byp_cnt_q != 16'hFFFF)
      byp_cnt_d = byp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      byp_cnt_q   <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      byp_cnt_q   <= byp_cnt_d;
    end
  end

  assign issue_cnt_o = issue_cnt_q;
  assign byp_cnt_o   = byp_cnt_q;
`endif

endmodule

// File: tb/tb_bf16_add_issue.sv
// Directed self-checking bench for bf16_add_issue (counter checks under BF16_ADD_ISSUE_CNT_EN).
module tb_bf16_add_issue;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bf16_add_issue_if bus();

`ifdef BF16_ADD_ISSUE_CNT_EN
  logic [15:0] issue_cnt, byp_cnt;
`endif

  bf16_add_issue dut (
    .clk(clk),
    .rst(rst),
`ifdef BF16_ADD_ISSUE_CNT_EN
    .issue_cnt_o(issue_cnt),
    .byp_cnt_o(byp_cnt),
`endif
    .bus(bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic rdy);
    bus.in_valid_i  = v;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.out_ready_i = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output fields repacked in operand order; for NORM pairs this equals {a, b}.
  function automatic logic [31:0] fields();
    return {bus.sa_o, bus.ea_o, bus.ma_o, bus.sb_o, bus.eb_o, bus.mb_o};
  endfunction

  function automatic logic [15:0] mk_a(input int k);
    logic [6:0] k7;
    k7 = 7'(k);
    return {1'b0, 8'h40, k7};
  endfunction

  function automatic logic [15:0] mk_b(input int k);
    logic [6:0] k7;
    k7 = 7'(k);
    return {1'b1, 8'h41, ~k7};
  endfunction

  logic [15:0] tab_a   [9] = '{16'h7F80, 16'h7FC1, 16'h8000, 16'h0001, 16'h0000,
                               16'hFF80, 16'h3F80, 16'h7F80, 16'h3F80};
  logic [15:0] tab_b   [9] = '{16'hFF80, 16'h3F80, 16'h8000, 16'h4040, 16'h8000,
                               16'h3F80, 16'h4000, 16'h7F80, 16'h8005};
  logic        tab_byp [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [15:0] tab_res [9] = '{16'h7FC0, 16'h7FC0, 16'h8000, 16'h4040, 16'h0000,
                               16'hFF80, 16'h0000, 16'h7F80, 16'h3F80};

  int issues;
  int order_err;
  int exp_idx;
  int stale;

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    checkOutput("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    checkOutput("rst_fields", fields(), 32'h0);
    checkOutput("rst_byp", {15'd0, bus.byp_o, bus.byp_res_o}, 32'h0);
    rst = 1'b0;

    // Single pair accepted in EMPTY shows up one cycle later.
    applyStimulus(1'b1, 16'h3F80, 16'h4000, 1'b1);
    step();
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("lat_out_valid", 32'(bus.out_valid_o), 32'd1);
    checkOutput("lat_ea", 32'(bus.ea_o), 32'h7F);
    checkOutput("lat_eb", 32'(bus.eb_o), 32'h80);
    checkOutput("lat_byp", 32'(bus.byp_o), 32'd0);
    checkOutput("lat_fields", fields(), 32'h3F80_4000);
    step();
    checkOutput("lat_drained", 32'(bus.out_valid_o), 32'd0);

    // Stall with three back-to-back pairs, then release.
    applyStimulus(1'b1, 16'h3F80, 16'h4000, 1'b0);
    step();
    checkOutput("stall_ready_1", 32'(bus.in_ready_o), 32'd1);
    applyStimulus(1'b1, 16'h4040, 16'hC0A0, 1'b0);
    step();
    checkOutput("stall_ready_2", 32'(bus.in_ready_o), 32'd0);
    checkOutput("stall_hold_a", fields(), 32'h3F80_4000);
    applyStimulus(1'b1, 16'h3E00, 16'hBF00, 1'b0);
    step();
    checkOutput("stall_hold_b", fields(), 32'h3F80_4000);
    checkOutput("stall_ready_3", 32'(bus.in_ready_o), 32'd0);
    checkOutput("stall_valid", 32'(bus.out_valid_o), 32'd1);
    applyStimulus(1'b1, 16'h3E00, 16'hBF00, 1'b1);
    step();
    checkOutput("order_p2_valid", 32'(bus.out_valid_o), 32'd1);
    checkOutput("order_p2", fields(), 32'h4040_C0A0);
    step();
    checkOutput("order_p3_valid", 32'(bus.out_valid_o), 32'd1);
    checkOutput("order_p3", fields(), 32'h3E00_BF00);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    step();
    checkOutput("order_drained", 32'(bus.out_valid_o), 32'd0);

    // Bypass table, streamed one vector per cycle.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, tab_a[i], tab_b[i], 1'b1);
      step();
      checkOutput($sformatf("byp_%0d", i), {15'd0, bus.byp_o, bus.byp_res_o},
                  {15'd0, tab_byp[i], tab_res[i]});
      if (i == 3)
        checkOutput("flush_ma", 32'(bus.ma_o), 32'd0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    step();

    // Fill to FULL, then reset with a competing accept on the same edge.
    applyStimulus(1'b1, 16'h3F80, 16'h4000, 1'b0);
    step();
    applyStimulus(1'b1, 16'h4040, 16'hC0A0, 1'b0);
    step();
    checkOutput("full_ready", 32'(bus.in_ready_o), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 16'h3E00, 16'hBF00, 1'b1);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    checkOutput("rstfull_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("rstfull_ready", 32'(bus.in_ready_o), 32'd1);
    checkOutput("rstfull_fields", fields(), 32'h0);
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.out_valid_o !== 1'b0) stale++;
    end
    checkOutput("rstfull_stale", 32'(stale), 32'd0);

    // Full-throughput stream of 100 pairs.
    issues    = 0;
    order_err = 0;
    exp_idx   = 0;
    for (int c = 0; c <= 100; c++) begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (fields() !== {mk_a(exp_idx), mk_b(exp_idx)}) order_err++;
        issues++;
        exp_idx++;
      end
      if (c < 100) applyStimulus(1'b1, mk_a(c), mk_b(c), 1'b1);
      else         applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      step();
    end
    checkOutput("tput_issues", 32'(issues), 32'd100);
    checkOutput("tput_order", 32'(order_err), 32'd0);
    checkOutput("tput_drained", 32'(bus.out_valid_o), 32'd0);

`ifdef BF16_ADD_ISSUE_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("cnt_rst_issue", 32'(issue_cnt), 32'd0);
    checkOutput("cnt_rst_byp", 32'(byp_cnt), 32'd0);
    for (int i = 0; i < 70000; i++) begin
      if (i == 10 || i == 20 || i == 30 || i == 40 || i == 50)
        applyStimulus(1'b1, 16'h7F80, 16'h3F80, 1'b1);
      else
        applyStimulus(1'b1, mk_a(i), mk_b(i), 1'b1);
      step();
      if (i == 11) checkOutput("cnt_early", 32'(issue_cnt), 32'd11);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
    step();
    step();
    checkOutput("cnt_issue_sat", 32'(issue_cnt), 32'h0000_FFFF);
    checkOutput("cnt_byp", 32'(byp_cnt), 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
